irrigation_scheduler: RTL and testbench

Parametrised N-zone irrigation controller that succeeds the fixed two-zone valve FSM. It accepts per-valve watering requests and grants zones round-robin, capping the number of simultaneously open zones. Each grant runs for a programmable, tick-based duration. New grants are gated on the tank level, and the block latches an error (empty tank or pressure fault) that closes every valve until software clears it.

---
 rtl/irrigation_scheduler_pkg.sv | 21 ++
 rtl/irrigation_scheduler_zone_timer.sv | 42 ++++
 rtl/irrigation_scheduler.sv | 151 +++++++++++++++
 tb/tb_irrigation_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irrigation_scheduler_pkg.sv
// Shared types and constants for the irrigation scheduler.
package irrigation_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ERROR = 2'd2
    } state_t;

    // Tank level encodings
    localparam logic [1:0] LVL_EMPTY = 2'b00;
    localparam logic [1:0] LVL_LOW   = 2'b01;
    localparam logic [1:0] LVL_OK    = 2'b10;
    localparam logic [1:0] LVL_FULL  = 2'b11;

    // Latched error causes
    localparam logic [1:0] ERR_EMPTY = 2'b01;
    localparam logic [1:0] ERR_FAULT = 2'b10;
    localparam logic [1:0] ERR_BOTH  = 2'b11;

endpackage

// File: rtl/irrigation_scheduler_zone_timer.sv
// Per-zone watering timer: tick-driven down-counter plus the zone's valve register.
module zone_timer #(
    parameter int N_VALVES = 2,
    parameter int DUR_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                tick,
    input  logic                clear,
    input  logic [DUR_W-1:0]    dur,
    input  logic [N_VALVES-1:0] mask,
    output logic [N_VALVES-1:0] valve,
    output logic                active,
    output logic                last
);

    logic [DUR_W-1:0] cnt;

    // Clear beats load beats tick; the valves drop on the same edge the count reaches zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            valve <= '0;
        end else if (clear) begin
            cnt   <= '0;
            valve <= '0;
        end else if (load) begin
            cnt   <= (dur == '0) ? DUR_W'(1) : dur;
            valve <= mask;
        end else if (tick && cnt != '0) begin
            cnt <= cnt - DUR_W'(1);
            if (cnt == DUR_W'(1)) begin
                valve <= '0;
            end
        end
    end

    assign active = (cnt != '0);
    assign last   = (cnt == DUR_W'(1));

endmodule

// File: rtl/irrigation_scheduler.sv
// N-zone irrigation scheduler: request pending, round-robin grants capped at MAX_ON, error latch.
module irrigation_scheduler #(
    parameter int N_ZONES  = 4,
    parameter int N_VALVES = 2,
    parameter int MAX_ON   = 2,
    parameter int DUR_W    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic [N_ZONES*N_VALVES-1:0]   req,
    input  logic [DUR_W-1:0]              dur,
    input  logic [1:0]                    lvl,
    input  logic                          fault,
    input  logic                          err_clr,
    output logic [N_ZONES*N_VALVES-1:0]   valve,
    output logic                          busy,
    output logic                          err,
    output logic [1:0]                    err_code,
    output logic [$clog2(N_ZONES+1)-1:0]  active_cnt
);

    import irrigation_pkg::*;

    localparam int CW = $clog2(N_ZONES + 1);
    localparam int ZW = $clog2(N_ZONES);

    state_t                             state, state_nx;
    logic [ZW-1:0]                      rr_ptr, rr_nx;
    logic [N_ZONES-1:0]                 pend, pend_nx;
    logic [N_ZONES-1:0][N_VALVES-1:0]   pend_mask, mask_nx;
    logic [N_ZONES-1:0]                 active, last, closing, grant_oh;
    logic [CW-1:0]                      cnt_after, cnt_nx;
    logic                               lvl_empty, lvl_usable, err_cond, err_entry;
    int unsigned                        idx;

    for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
        zone_timer #(
            .N_VALVES (N_VALVES),
            .DUR_W    (DUR_W)
        ) u_timer (
            .clk    (clk),
            .reset  (reset),
            .load   (grant_oh[z]),
            .tick   (tick),
            .clear  (err_entry),
            .dur    (dur),
            .mask   (pend_mask[z]),
            .valve  (valve[z*N_VALVES +: N_VALVES]),
            .active (active[z]),
            .last   (last[z])
        );
    end

    // Error detection, slot count after this cycle's closures, and round-robin grant pick.
    always_comb begin
        lvl_empty  = (lvl == LVL_EMPTY);
        lvl_usable = (lvl != LVL_EMPTY) && (lvl != LVL_LOW);
        err_cond   = fault || (lvl_empty && (|active || |pend));
        err_entry  = (state != ERROR) && err_cond;
        closing    = active & last & {N_ZONES{tick}};
        cnt_after  = '0;
        for (int unsigned i = 0; i < N_ZONES; i++) begin
            cnt_after = cnt_after + CW'(active[i] & ~closing[i]);
        end
        grant_oh = '0;
        rr_nx    = rr_ptr;
        idx      = 0;
        if (state == RUN && !err_entry && lvl_usable && int'(cnt_after) < MAX_ON) begin
            for (int unsigned i = 0; i < N_ZONES; i++) begin
                idx = (32'(rr_ptr) + i) % N_ZONES;
                if (grant_oh == '0 && pend[idx]) begin
                    grant_oh[idx] = 1'b1;
                    rr_nx         = ZW'((idx + 1) % N_ZONES);
                end
            end
        end
        cnt_nx = '0;
        if (!err_entry) begin
            for (int unsigned i = 0; i < N_ZONES; i++) begin
                cnt_nx = cnt_nx + CW'((active[i] & ~closing[i]) | grant_oh[i]);
            end
        end
    end

    // Pend bookkeeping: idle zones accumulate requested valves; grant or error entry wipes them.
    always_comb begin
        pend_nx = pend;
        mask_nx = pend_mask;
        for (int unsigned z = 0; z < N_ZONES; z++) begin
            if (state != ERROR && !active[z] && |req[z*N_VALVES +: N_VALVES]) begin
                pend_nx[z] = 1'b1;
                mask_nx[z] = pend_mask[z] | req[z*N_VALVES +: N_VALVES];
            end
            if (grant_oh[z]) begin
                pend_nx[z] = 1'b0;
                mask_nx[z] = '0;
            end
        end
        if (err_entry) begin
            pend_nx = '0;
            mask_nx = '0;
        end
    end

    // Next-state logic; leaving IDLE looks at pends being set this edge so grants start one cycle later.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (err_cond)      state_nx = ERROR;
                else if (|pend_nx) state_nx = RUN;
            end
            RUN: begin
                if (err_cond)                 state_nx = ERROR;
                else if (!(|active) && !(|pend)) state_nx = IDLE;
            end
            ERROR: begin
                if (err_clr && !lvl_empty && !fault) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Control registers: state, arbiter pointer, pends, error cause and open-zone count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            pend       <= '0;
            pend_mask  <= '0;
            err_code   <= '0;
            active_cnt <= '0;
        end else begin
            state      <= state_nx;
            rr_ptr     <= rr_nx;
            pend       <= pend_nx;
            pend_mask  <= mask_nx;
            active_cnt <= cnt_nx;
            if (err_entry) begin
                err_code <= (fault && lvl_empty) ? ERR_BOTH : (fault ? ERR_FAULT : ERR_EMPTY);
            end else if (state == ERROR && state_nx == IDLE) begin
                err_code <= '0;
            end
        end
    end

    assign busy = (state != IDLE);
    assign err  = (state == ERROR);

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Scoreboard bench for irrigation_scheduler: directed scenarios plus random traffic vs a behavioural model.
module tb_irrigation_scheduler;

    localparam int NZ    = 4;
    localparam int NV    = 2;
    localparam int MAXON = 2;
    localparam int DW    = 8;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_ERR  = 2;

    logic             clk = 1'b0;
    logic             reset, tick, fault, err_clr;
    logic [NZ*NV-1:0] req;
    logic [DW-1:0]    dur;
    logic [1:0]       lvl;
    logic [NZ*NV-1:0] valve;
    logic             busy, err;
    logic [1:0]       err_code;
    logic [2:0]       active_cnt;

    irrigation_scheduler #(
        .N_ZONES  (NZ),
        .N_VALVES (NV),
        .MAX_ON   (MAXON),
        .DUR_W    (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .req        (req),
        .dur        (dur),
        .lvl        (lvl),
        .fault      (fault),
        .err_clr    (err_clr),
        .valve      (valve),
        .busy       (busy),
        .err        (err),
        .err_code   (err_code),
        .active_cnt (active_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NZ*NV-1:0] valve;
        logic             busy;
        logic             err;
        logic [1:0]       code;
        logic [2:0]       cnt;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Behavioural reference state
    int          m_timer[NZ];
    bit [NV-1:0] m_vmask[NZ];
    bit          m_pend[NZ];
    bit [NV-1:0] m_pmask[NZ];
    int          m_rr;
    int          m_mode;
    bit [1:0]    m_code;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int z = 0; z < NZ; z++) begin
            m_timer[z] = 0; m_vmask[z] = '0; m_pend[z] = 0; m_pmask[z] = '0;
        end
        m_rr = 0; m_mode = M_IDLE; m_code = 2'b00;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        for (int z = 0; z < NZ; z++) begin
            e.valve[z*NV +: NV] = m_vmask[z];
            if (m_timer[z] > 0) e.cnt = e.cnt + 3'd1;
        end
        e.busy = (m_mode != M_IDLE);
        e.err  = (m_mode == M_ERR);
        e.code = m_code;
        return e;
    endfunction

    // One clock edge of the controller described in plain rules
    task automatic model_step(input logic [NZ*NV-1:0] r, input int d, input logic [1:0] l,
                              input logic f, input logic c, input logic t);
        int          open_before, open_now, g, z;
        bit          pend_before, any;
        bit          was_act[NZ];
        bit [NV-1:0] zb;
        open_before = 0; pend_before = 0;
        for (int k = 0; k < NZ; k++) begin
            was_act[k] = (m_timer[k] > 0);
            if (was_act[k]) open_before++;
            if (m_pend[k]) pend_before = 1;
        end
        if (m_mode == M_ERR) begin
            if (c && l != 2'b00 && !f) begin m_mode = M_IDLE; m_code = 2'b00; end
            return;
        end
        if (f || (l == 2'b00 && (open_before > 0 || pend_before))) begin
            for (int k = 0; k < NZ; k++) begin
                m_timer[k] = 0; m_vmask[k] = '0; m_pend[k] = 0; m_pmask[k] = '0;
            end
            m_code = {f, (l == 2'b00)};
            m_mode = M_ERR;
            return;
        end
        for (int k = 0; k < NZ; k++) begin
            if (t && m_timer[k] > 0) begin
                m_timer[k]--;
                if (m_timer[k] == 0) m_vmask[k] = '0;
            end
        end
        g = -1;
        if (m_mode == M_RUN && l >= 2'b10) begin
            open_now = 0;
            for (int k = 0; k < NZ; k++) if (m_timer[k] > 0) open_now++;
            if (open_now < MAXON) begin
                for (int k = 0; k < NZ; k++) begin
                    z = (m_rr + k) % NZ;
                    if (g < 0 && m_pend[z]) g = z;
                end
            end
        end
        if (g >= 0) begin
            m_timer[g] = (d == 0) ? 1 : d;
            m_vmask[g] = m_pmask[g];
            m_pend[g]  = 0;
            m_pmask[g] = '0;
            m_rr       = (g + 1) % NZ;
        end
        for (int k = 0; k < NZ; k++) begin
            zb = r[k*NV +: NV];
            if (!was_act[k] && k != g && zb != '0) begin
                m_pend[k]  = 1;
                m_pmask[k] = m_pmask[k] | zb;
            end
        end
        any = 0;
        for (int k = 0; k < NZ; k++) if (m_pend[k]) any = 1;
        if (m_mode == M_IDLE) begin
            if (any) m_mode = M_RUN;
        end else if (open_before == 0 && !pend_before) begin
            m_mode = M_IDLE;
        end
    endtask

    task automatic cycle(input logic [NZ*NV-1:0] r, input int d, input logic [1:0] l,
                         input logic f, input logic c, input logic t);
        req = r; dur = DW'(d); lvl = l; fault = f; err_clr = c; tick = t;
        model_step(r, d, l, f, c, t);
        @(posedge clk);
        sbq.push_back(model_out());
        #1;
    endtask

    // Monitor: compare every expected post-edge state against the DUT mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("valve", 32'(valve), 32'(e.valve));
                chk("busy", 32'(busy), 32'(e.busy));
                chk("err", 32'(err), 32'(e.err));
                chk("err_code", 32'(err_code), 32'(e.code));
                chk("active_cnt", 32'(active_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        logic [NZ*NV-1:0] r;
        logic [1:0]       l;
        int               x;
        reset = 1'b1; req = '0; dur = '0; lvl = 2'b10; fault = 0; err_clr = 0; tick = 0;
        model_reset();
        #12;
        chk("reset_valve", 32'(valve), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_err", 32'(err), 0);
        chk("reset_code", 32'(err_code), 0);
        chk("reset_cnt", 32'(active_cnt), 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic grant and timeout, dur=3
        cycle(8'h01, 3, 2'b10, 0, 0, 0);
        repeat (2) cycle(8'h00, 3, 2'b10, 0, 0, 0);
        repeat (6) cycle(8'h00, 3, 2'b10, 0, 0, 1);

        // All zones at once: cap and round-robin order
        cycle(8'hFF, 5, 2'b10, 0, 0, 0);
        repeat (3) cycle(8'h00, 5, 2'b10, 0, 0, 0);
        repeat (16) cycle(8'h00, 5, 2'b10, 0, 0, 1);

        // dur=0 treated as one tick
        cycle(8'h10, 0, 2'b10, 0, 0, 0);
        repeat (2) cycle(8'h00, 0, 2'b10, 0, 0, 0);
        repeat (3) cycle(8'h00, 0, 2'b10, 0, 0, 1);

        // Low level blocks grant to zone1 until level recovers
        cycle(8'h04, 2, 2'b01, 0, 0, 0);
        repeat (4) cycle(8'h00, 2, 2'b01, 0, 0, 0);
        repeat (3) cycle(8'h00, 2, 2'b10, 0, 0, 0);
        repeat (4) cycle(8'h00, 2, 2'b10, 0, 0, 1);

        // Empty tank while zone0 open, then acknowledge
        cycle(8'h02, 9, 2'b10, 0, 0, 0);
        repeat (3) cycle(8'h00, 9, 2'b10, 0, 0, 0);
        cycle(8'h00, 9, 2'b00, 0, 0, 0);
        cycle(8'h03, 9, 2'b00, 0, 1, 0);
        cycle(8'h00, 9, 2'b10, 0, 1, 0);
        cycle(8'h00, 9, 2'b10, 0, 0, 0);

        // Fault and empty together
        cycle(8'h40, 9, 2'b11, 0, 0, 0);
        repeat (3) cycle(8'h00, 9, 2'b11, 0, 0, 0);
        cycle(8'h00, 9, 2'b00, 1, 0, 0);
        cycle(8'h00, 9, 2'b10, 1, 1, 0);
        cycle(8'h00, 9, 2'b10, 0, 1, 0);

        // Asynchronous reset in the middle of a grant
        cycle(8'h01, 9, 2'b10, 0, 0, 0);
        repeat (3) cycle(8'h00, 9, 2'b10, 0, 0, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_valve", 32'(valve), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_cnt", 32'(active_cnt), 0);
        chk("midrst_err", 32'(err), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 3) == 0) ? (NZ*NV)'($urandom) : '0;
            x = $urandom_range(0, 63);
            if (x == 0)      l = 2'b00;
            else if (x <= 6) l = 2'b01;
            else             l = 2'($urandom_range(2, 3));
            cycle(r, $urandom_range(0, 6), l, ($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        repeat (2) cycle('0, 1, 2'b10, 0, 1, 1);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sbq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
